switch_event_arbiter: RTL

SWITCH_EVENT_ARBITER -- requirements
Module: switch_event_arbiter

---
 rtl/switch_event_arbiter.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/switch_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : switch_event_arbiter
//  Purpose  : Debounces NUM_SW noisy switches and turns each debounced press
//             into an event, offered one at a time through a valid/ready port
//             with round-robin fairness. Presses that arrive while the same
//             switch still has an undelivered event raise a sticky overflow.
//  Options  : define LONG_PRESS_EN to add per-switch hold counters that raise
//             a second, long-press event after LONG_TICKS ticks held.
//  Revision : 1.0  initial release
// ============================================================================
module switch_event_arbiter #(
    parameter  int NUM_SW       = 4,
    parameter  int TICK_DIV     = 25000,
    parameter  int STABLE_TICKS = 10,
    parameter  int LONG_TICKS   = 1000,
    localparam int ID_W         = (NUM_SW > 1) ? $clog2(NUM_SW) : 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_SW-1:0] i_Switch,
    input  logic              i_Ready,
    output logic              o_Valid,
    output logic [ID_W-1:0]   o_Id,
    output logic              o_Long,
    output logic [NUM_SW-1:0] o_State,
    output logic [NUM_SW-1:0] o_Overflow
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STB_W = $clog2(STABLE_TICKS + 1);

    // ------------------------------------------------------------------------
    // Input synchronizers and shared sample-tick prescaler
    // ------------------------------------------------------------------------
    logic [NUM_SW-1:0] sync1_q;
    logic [NUM_SW-1:0] sync2_q;
    logic [PRE_W-1:0]  presc_q;
    logic              tick;

    assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

    // Two-flop synchronizer for every raw switch level
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
        end
    end

    // Free-running prescaler, wraps after TICK_DIV-1
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-switch debounce (and optional hold timing)
    // ------------------------------------------------------------------------
    logic [NUM_SW-1:0] state_vec;
    logic [NUM_SW-1:0] long_hit;

    generate
        for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
            logic [STB_W-1:0] stb_q;
            logic             lvl_q;

            // Accept a new level only after STABLE_TICKS consecutive differing samples
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    stb_q <= '0;
                    lvl_q <= 1'b0;
                end else if (tick) begin
                    if (sync2_q[i] != lvl_q) begin
                        if (stb_q == STB_W'(STABLE_TICKS - 1)) begin
                            stb_q <= '0;
                            lvl_q <= sync2_q[i];
                        end else begin
                            stb_q <= stb_q + 1'b1;
                        end
                    end else begin
                        stb_q <= '0;
                    end
                end
            end

            assign state_vec[i] = lvl_q;

`ifdef LONG_PRESS_EN
            localparam int HOLD_W = $clog2(LONG_TICKS + 1);
            logic [HOLD_W-1:0] hold_q;

            // Count held ticks; saturating at LONG_TICKS gives one hit per hold
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    hold_q <= '0;
                end else if (tick) begin
                    if (lvl_q) begin
                        if (hold_q != HOLD_W'(LONG_TICKS)) begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end else begin
                        hold_q <= '0;
                    end
                end
            end

            assign long_hit[i] = tick && lvl_q && (hold_q == HOLD_W'(LONG_TICKS - 1));
`else
            assign long_hit[i] = 1'b0;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Press detection and request bookkeeping
    // ------------------------------------------------------------------------
    logic [NUM_SW-1:0] state_dly_q;
    logic [NUM_SW-1:0] pend_q;
    logic [NUM_SW-1:0] ovf_q;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] req;
    logic [NUM_SW-1:0] clr_pend;
    logic [NUM_SW-1:0] gnt_mask;
    logic              gnt_fire;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   last_q;

    assign rise = state_vec & ~state_dly_q;

    // Delayed debounced level, used to find rising edges of o_State
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_dly_q <= '0;
        end else begin
            state_dly_q <= state_vec;
        end
    end

    // A new press sets its request; a grant clears it, but a simultaneous set
    // wins. Pressing again before the old event is taken is flagged as lost.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_pend) | rise;
            ovf_q  <= ovf_q | (rise & pend_q & ~clr_pend);
        end
    end

`ifdef LONG_PRESS_EN
    logic [NUM_SW-1:0] lpend_q;
    logic [NUM_SW-1:0] clr_lpend;
    logic              gnt_long;

    // Long-press requests, served only when no short press is waiting
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            lpend_q <= '0;
        end else begin
            lpend_q <= (lpend_q & ~clr_lpend) | long_hit;
        end
    end

    assign req       = pend_q | lpend_q;
    assign gnt_long  = ~pend_q[gnt_idx];
    assign clr_pend  = (gnt_fire && !gnt_long) ? gnt_mask : '0;
    assign clr_lpend = (gnt_fire &&  gnt_long) ? gnt_mask : '0;
`else
    assign req       = pend_q;
    assign clr_pend  = gnt_fire ? gnt_mask : '0;
`endif

    // ------------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } fsm_t;

    fsm_t            fsm_q;
    logic            valid_q;
    logic [ID_W-1:0] id_q;

    assign gnt_fire = (fsm_q == S_IDLE) && gnt_found;
    assign gnt_mask = NUM_SW'(1) << gnt_idx;

    // First requester found searching upward from the switch after last grant
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SW; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_SW);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

`ifdef LONG_PRESS_EN
    logic long_q;
    assign o_Long = long_q;
`else
    assign o_Long = 1'b0;
`endif

    // Offer FSM with registered valid/id/long; the offer holds until accepted
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            fsm_q   <= S_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_SW - 1);
`ifdef LONG_PRESS_EN
            long_q  <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        valid_q <= 1'b1;
                        id_q    <= gnt_idx;
`ifdef LONG_PRESS_EN
                        long_q  <= gnt_long;
`endif
                        fsm_q   <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (i_Ready) begin
                        valid_q <= 1'b0;
                        last_q  <= id_q;
                        fsm_q   <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    fsm_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Valid    = valid_q;
    assign o_Id       = id_q;
    assign o_State    = state_vec;
    assign o_Overflow = ovf_q;

endmodule
`default_nettype wire
